// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls, imem port and IF/ID outputs.
interface if_fetch_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             pc_sel;
    logic [XLEN-1:0]  branch_target;
    logic             stall;
    logic [XLEN-1:0]  imem_addr;
    logic [XLEN-1:0]  imem_rdata;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  if_id_pc;
    logic [XLEN-1:0]  if_id_instr;
    logic             if_id_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        input  pc_sel, branch_target, stall, imem_rdata,
        output imem_addr, pc, if_id_pc, if_id_instr, if_id_valid,
        output misalign_err, fetch_cnt, bubble_cnt
    );

    modport slave (
        output pc_sel, branch_target, stall, imem_rdata,
        input  imem_addr, pc, if_id_pc, if_id_instr, if_id_valid,
        input  misalign_err, fetch_cnt, bubble_cnt
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, synchronous imem address, IF/ID register.
module if_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input logic         clk,
    input logic         rst,
    if_fetch_if.master  bus
);
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             warm_q;
    logic [XLEN-1:0]  ipc_q, ipc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             redirect;
    logic             bubble;

    assign redirect = ~bus.pc_sel;
    assign bubble   = redirect | bus.stall | ~warm_q;

    // Redirect has priority over stall; the target is force-aligned.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (redirect) begin
            pc_d = {bus.branch_target[XLEN-1:2], 2'b00};
        end else if (bus.stall || !warm_q) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        ipc_d   = ipc_q;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q + CNT_W'(1);
        mis_d   = redirect && (bus.branch_target[1:0] != 2'b00);
        if (!bubble) begin
            ipc_d   = pc_q;
            instr_d = bus.imem_rdata;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + CNT_W'(1);
            bcnt_d  = bcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            warm_q  <= 1'b0;
            ipc_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            warm_q  <= 1'b1;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign bus.imem_addr    = pc_d;
    assign bus.pc           = pc_q;
    assign bus.if_id_pc     = ipc_q;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.misalign_err = mis_q;
    assign bus.fetch_cnt    = fcnt_q;
    assign bus.bubble_cnt   = bcnt_q;
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the synchronous instruction memory, and loads the IF/ID pipeline register. It consumes the `pc_sel` redirect from execute and the `stall` output of the stall controller. A taken redirect steers the PC immediately; stall holds the PC and injects NOP bubbles into IF/ID until the controller releases it.

## Interface
- `XLEN`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC value on reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)
- `CNT_W`, 16, width of the performance counters

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_sel` in 1: 0 = redirect to `branch_target` (taken branch/jump); 1 = sequential.
- `branch_target` in XLEN: redirect address, valid when `pc_sel`=0.
- `stall` in 1: from the stall controller; 1 = hold PC and bubble IF/ID.
- `imem_addr` out XLEN: fetch address, combinational (= next_pc).
- `imem_rdata` in XLEN: instruction memory data. It holds the word at the address sampled on the previous edge.
- `pc` out XLEN: current PC register.
- `if_id_pc` out XLEN: PC of the instruction in IF/ID.
- `if_id_instr` out XLEN: instruction in IF/ID.
- `if_id_valid` out 1: 1 = real instruction; 0 = bubble.
- `misalign_err` out 1: one-cycle pulse, registered; redirect target had `[1:0]` != 0.
- `fetch_cnt` out CNT_W: count of valid instructions loaded into IF/ID.
- `bubble_cnt` out CNT_W: count of bubbles loaded into IF/ID.

## Operation
- `next_pc` priority, evaluated combinationally:
  - `pc_sel`=0 → `{branch_target[XLEN-1:2],2'b00}`.
  - else `stall`=1 or `warm`=0 → `pc`.
  - else `pc+4`, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Redirect beats stall when both are active in the same cycle.
- `imem_addr` = `next_pc`. Because the memory read is synchronous, `imem_rdata` during any cycle is the word at the current `pc`.
- `warm` flop:
  - 0 in reset; set to 1 on the first edge after reset release.
  - While `warm`=0 the stage bubbles and the PC holds.
- On each edge, `pc` <= `next_pc`.
- IF/ID update on each edge:
  - Bubble if `pc_sel`=0, `stall`=1 or `warm`=0: `if_id_instr` <= `NOP_INSTR`, `if_id_valid` <= 0, `if_id_pc` holds; `bubble_cnt` increments.
  - Else: `if_id_instr` <= `imem_rdata`, `if_id_pc` <= `pc`, `if_id_valid` <= 1; `fetch_cnt` increments.
- Counters wrap modulo 2^CNT_W and have no saturation.
- `misalign_err` <= (`pc_sel`=0 and `branch_target[1:0]`!=0). It is the only reaction to a misaligned target; the target is force-aligned and fetch continues.

## Timing
- Reset values, applied asynchronously:
  - `pc`=`RESET_PC`, `warm`=0.
  - `if_id_pc`=`RESET_PC`, `if_id_instr`=`NOP_INSTR`, `if_id_valid`=0.
  - `misalign_err`=0, `fetch_cnt`=0, `bubble_cnt`=0.
- After reset release:
  - Edge 1: `warm` is set and a bubble is loaded.
  - Edge 2: IF/ID holds `RESET_PC` with `valid`=1.
  - Thereafter, one instruction per cycle while unstalled.
- Fetch latency: an instruction appears in IF/ID one edge after `pc` takes its address.
- Redirect sampled at edge E0 (`pc_sel`=0):
  - `pc`=T after E0; bubble at E0.
  - The stall controller holds `stall`=1 across E1–E3; bubbles at E1–E3, PC holds T.
  - First valid IF/ID = (T, mem[T]) at E4, for 4 bubbles per redirect.
- A second redirect during a stall window retargets immediately; bubbling continues for as long as `stall` stays asserted.
- Reset mid-operation clears the stage at once. The pipeline restarts from `RESET_PC` via the `warm` bubble.
- `stall` is used as a level; no edge detection.

## Test plan
- Reset release with a preloaded memory (mem[0]=A, mem[4]=B):
  - Edge 1: bubble.
  - Edge 2: IF/ID=(0,A,1).
  - Edge 3: IF/ID=(4,B,1); `fetch_cnt`=2, `bubble_cnt`=1.
- Redirect at PC 0x10 to 0x40 driven through a real stall controller: exactly 4 bubbles, then IF/ID=(0x40, mem[0x40], 1), then (0x44, …).
- `pc_sel`=0 with `branch_target`=0x102 while `stall`=1:
  - `pc`=0x100 next cycle; `misalign_err` pulses for 1 cycle.
  - IF/ID remains a bubble.
- Run sequential fetch from `pc`=0xFFFF_FFF8: PC sequence FFF8→FFFC→0 with valid instructions and no bubbles.
- Assert `rst` asynchronously mid-cycle during a stall window: all outputs reach their reset values before the next edge; recovery matches the reset scenario.
- Preload `bubble_cnt`=0xFFFF via 65535 stall cycles, then one more bubble → `bubble_cnt`=0; `fetch_cnt` unchanged.
